// File: rtl/ysyx_23060332_mem_arbiter_if.sv
// ysyx_23060332_mem_arbiter_if: IFU/LSU request, memory command and response signals of the arbiter
interface ysyx_23060332_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MASK_W = 8
);
    logic              ifu_req_valid;
    logic              ifu_req_ready;
    logic [ADDR_W-1:0] ifu_addr;
    logic              ifu_resp_valid;
    logic [DATA_W-1:0] ifu_rdata;
    logic              ifu_resp_err;
    logic              lsu_req_valid;
    logic              lsu_req_ready;
    logic [ADDR_W-1:0] lsu_addr;
    logic              lsu_wen;
    logic [DATA_W-1:0] lsu_wdata;
    logic [MASK_W-1:0] lsu_wmask;
    logic              lsu_resp_valid;
    logic [DATA_W-1:0] lsu_rdata;
    logic              lsu_resp_err;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wen;
    logic [DATA_W-1:0] mem_wdata;
    logic [MASK_W-1:0] mem_wmask;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  ifu_req_valid, ifu_addr, lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
               mem_req_ready, mem_resp_valid, mem_rdata,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
               lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
               mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, busy
    );

    modport master (
        output ifu_req_valid, ifu_addr, lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
               mem_req_ready, mem_resp_valid, mem_rdata,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
               lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
               mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, busy
    );
endinterface

// File: rtl/ysyx_23060332_mem_arbiter.sv
// ysyx_23060332_mem_arbiter: shares one memory port between IFU and LSU, one transaction in flight
module ysyx_23060332_mem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MASK_W         = 8,
    parameter int MAX_LSU_STREAK = 4,
    parameter int TIMEOUT        = 255
) (
    input logic                       clk,
    input logic                       rst_n,
    ysyx_23060332_mem_arbiter_if.slave io_bus
);
    localparam int SW = $clog2(MAX_LSU_STREAK + 1);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    state_t            r_state, w_next;
    logic              r_owner_lsu;
    logic [SW-1:0]     r_streak;
    logic [CW-1:0]     r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_wen;
    logic [DATA_W-1:0] r_wdata;
    logic [MASK_W-1:0] r_wmask;
    logic              r_resp_valid;
    logic              r_resp_err;
    logic [DATA_W-1:0] r_rdata;
    logic              w_idle, w_ifu_due, w_grant_lsu, w_grant_ifu, w_wait, w_timeout, w_done;

    // An LSU grant with IFU waiting needs streak < MAX, so the streak can never pass MAX.
    assign w_idle      = r_state == IDLE;
    assign w_wait      = r_state == WAIT;
    assign w_ifu_due   = io_bus.ifu_req_valid && r_streak == SW'(MAX_LSU_STREAK);
    assign w_grant_lsu = w_idle && io_bus.lsu_req_valid && !w_ifu_due;
    assign w_grant_ifu = w_idle && io_bus.ifu_req_valid && !w_grant_lsu;
    assign w_timeout   = w_wait && !io_bus.mem_resp_valid && r_cnt == CW'(TIMEOUT - 1);
    assign w_done      = w_wait && (io_bus.mem_resp_valid || w_timeout);

    assign io_bus.ifu_req_ready  = w_grant_ifu;
    assign io_bus.lsu_req_ready  = w_grant_lsu;
    assign io_bus.mem_req_valid  = r_state == REQ;
    assign io_bus.mem_addr       = r_addr;
    assign io_bus.mem_wen        = r_wen;
    assign io_bus.mem_wdata      = r_wdata;
    assign io_bus.mem_wmask      = r_wmask;
    assign io_bus.busy           = !w_idle;
    assign io_bus.ifu_resp_valid = r_resp_valid && !r_owner_lsu;
    assign io_bus.ifu_resp_err   = r_resp_err && !r_owner_lsu;
    assign io_bus.ifu_rdata      = r_owner_lsu ? '0 : r_rdata;
    assign io_bus.lsu_resp_valid = r_resp_valid && r_owner_lsu;
    assign io_bus.lsu_resp_err   = r_resp_err && r_owner_lsu;
    assign io_bus.lsu_rdata      = r_owner_lsu ? r_rdata : '0;

    // Next state: accept -> present command -> wait for response or timeout.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (w_grant_lsu || w_grant_ifu) ? REQ : IDLE;
            REQ:     w_next = io_bus.mem_req_ready ? WAIT : REQ;
            WAIT:    w_next = w_done ? IDLE : WAIT;
            default: w_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Latch the winner's command, owner and LSU streak on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_wen       <= 1'b0;
            r_wdata     <= '0;
            r_wmask     <= '0;
            r_owner_lsu <= 1'b0;
            r_streak    <= '0;
        end else if (w_grant_lsu || w_grant_ifu) begin
            r_addr      <= w_grant_lsu ? io_bus.lsu_addr : io_bus.ifu_addr;
            r_wen       <= w_grant_lsu && io_bus.lsu_wen;
            r_wdata     <= w_grant_lsu ? io_bus.lsu_wdata : '0;
            r_wmask     <= w_grant_lsu ? io_bus.lsu_wmask : '0;
            r_owner_lsu <= w_grant_lsu;
            r_streak    <= (w_grant_lsu && io_bus.ifu_req_valid) ? r_streak + SW'(1) : '0;
        end
    end

    // Watchdog counts WAIT cycles and restarts whenever WAIT is left.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cnt <= '0;
        else        r_cnt <= (w_wait && !w_done) ? r_cnt + CW'(1) : '0;
    end

    // One-cycle response; stores and timeouts return zero data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_rdata      <= '0;
        end else begin
            r_resp_valid <= w_done;
            r_resp_err   <= w_timeout;
            r_rdata      <= (w_wait && io_bus.mem_resp_valid && !r_wen) ? io_bus.mem_rdata : '0;
        end
    end
endmodule
